// File: rtl/cpu_pkg.sv
// Shared Beaker8 CPU definitions: ALU opcodes and flag bit positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'h0,
        ALUOP_ADC  = 4'h1,
        ALUOP_SUB  = 4'h2,
        ALUOP_SBC  = 4'h3,
        ALUOP_AND  = 4'h4,
        ALUOP_OR   = 4'h5,
        ALUOP_XOR  = 4'h6,
        ALUOP_NOT  = 4'h7,
        ALUOP_SHL  = 4'h8,
        ALUOP_SHR  = 4'h9,
        ALUOP_ROL  = 4'hA,
        ALUOP_ROR  = 4'hB,
        ALUOP_INC  = 4'hC,
        ALUOP_DEC  = 4'hD,
        ALUOP_CMP  = 4'hE,
        ALUOP_PASS = 4'hF
    } aluop_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/cpu_alu_if.sv
// ALU bus: opcode, operands and flags in; registered result and flags out.
interface cpu_alu_if;
    import cpu_pkg::*;

    aluop_t     operation;
    logic [3:0] flagsIn;
    logic [7:0] leftOperand;
    logic [7:0] rightOperand;
    logic [7:0] resultOut;
    logic [3:0] flagsOut;

    modport master (
        output operation, flagsIn, leftOperand, rightOperand,
        input  resultOut, flagsOut
    );

    modport slave (
        input  operation, flagsIn, leftOperand, rightOperand,
        output resultOut, flagsOut
    );

endinterface

// File: rtl/cpu_alu_core.sv
// Combinational ALU datapath: next result and next flags for one operation.
module cpu_alu_core
    import cpu_pkg::*;
(
    input  aluop_t     op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] flags_i,
    output logic [7:0] result_o,
    output logic [3:0] flags_o
);

    logic       cin;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       add_ovf;
    logic       sub_ovf;

    assign cin = flags_i[FLAG_C];

    // Carry/borrow in only participates for ADC and SBC.
    assign sum9  = {1'b0, a_i} + {1'b0, b_i} + {8'd0, (op_i == ALUOP_ADC) & cin};
    assign diff9 = {1'b0, a_i} - {1'b0, b_i} - {8'd0, (op_i == ALUOP_SBC) & cin};

    assign add_ovf = (a_i[7] == b_i[7]) && (sum9[7] != a_i[7]);
    assign sub_ovf = (a_i[7] != b_i[7]) && (diff9[7] != a_i[7]);

    always_comb begin
        logic [7:0] zn_src;
        result_o = 8'h00;
        flags_o  = flags_i;
        zn_src   = 8'h00;
        case (op_i)
            ALUOP_ADD, ALUOP_ADC: begin
                result_o        = sum9[7:0];
                flags_o[FLAG_C] = sum9[8];
                flags_o[FLAG_V] = add_ovf;
            end
            ALUOP_SUB, ALUOP_SBC, ALUOP_CMP: begin
                result_o        = (op_i == ALUOP_CMP) ? a_i : diff9[7:0];
                flags_o[FLAG_C] = diff9[8];
                flags_o[FLAG_V] = sub_ovf;
            end
            ALUOP_AND, ALUOP_OR, ALUOP_XOR, ALUOP_NOT: begin
                result_o = (op_i == ALUOP_AND) ? (a_i & b_i) :
                           (op_i == ALUOP_OR)  ? (a_i | b_i) :
                           (op_i == ALUOP_XOR) ? (a_i ^ b_i) : ~a_i;
                flags_o[FLAG_C] = 1'b0;
                flags_o[FLAG_V] = 1'b0;
            end
            ALUOP_SHL, ALUOP_ROL: begin
                result_o        = {a_i[6:0], (op_i == ALUOP_ROL) & cin};
                flags_o[FLAG_C] = a_i[7];
                flags_o[FLAG_V] = 1'b0;
            end
            ALUOP_SHR, ALUOP_ROR: begin
                result_o        = {(op_i == ALUOP_ROR) & cin, a_i[7:1]};
                flags_o[FLAG_C] = a_i[0];
                flags_o[FLAG_V] = 1'b0;
            end
            ALUOP_INC: begin
                result_o        = a_i + 8'd1;
                flags_o[FLAG_V] = (a_i == 8'h7F);
            end
            ALUOP_DEC: begin
                result_o        = a_i - 8'd1;
                flags_o[FLAG_V] = (a_i == 8'h80);
            end
            ALUOP_PASS: begin
                result_o = b_i;
            end
            default: begin
                result_o = 8'h00;
            end
        endcase
        // CMP reports Z/N of the difference while returning A unchanged.
        zn_src          = (op_i == ALUOP_CMP) ? diff9[7:0] : result_o;
        flags_o[FLAG_Z] = (zn_src == 8'h00);
        flags_o[FLAG_N] = zn_src[7];
    end

endmodule

// File: rtl/cpu_alu.sv
// Beaker8 ALU top: registers the core's result and flags, one-cycle latency.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    cpu_alu_if.slave   alu
);

    logic [7:0] result_d, result_q;
    logic [3:0] flags_d,  flags_q;

    cpu_alu_core u_core (
        .op_i     (alu.operation),
        .a_i      (alu.leftOperand),
        .b_i      (alu.rightOperand),
        .flags_i  (alu.flagsIn),
        .result_o (result_d),
        .flags_o  (flags_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= 8'h00;
            flags_q  <= 4'h0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign alu.resultOut = result_q;
    assign alu.flagsOut  = flags_q;

endmodule

// File: tb/tb_cpu_alu.sv
// Directed-vector bench for cpu_alu; flags are written {V,N,Z,C}.
module tb_cpu_alu;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    cpu_alu_if alu_bus ();

    cpu_alu dut (
        .clk   (clk),
        .reset (reset),
        .alu   (alu_bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        aluop_t     op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fin;
        logic [7:0] exp_r;
        logic [3:0] exp_f;
        string      name;
    } vec_t;

    vec_t vecs [20];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input aluop_t op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fin);
        alu_bus.operation    = op;
        alu_bus.leftOperand  = a;
        alu_bus.rightOperand = b;
        alu_bus.flagsIn      = fin;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{ALUOP_ADD,  8'h7F, 8'h01, 4'h0, 8'h80, 4'hC, "add_7f_01"};
        vecs[1]  = '{ALUOP_ADD,  8'hFF, 8'h01, 4'h0, 8'h00, 4'h3, "add_ff_01"};
        vecs[2]  = '{ALUOP_SUB,  8'h05, 8'h06, 4'h0, 8'hFF, 4'h5, "sub_05_06"};
        vecs[3]  = '{ALUOP_CMP,  8'h80, 8'h01, 4'h0, 8'h80, 4'h8, "cmp_80_01"};
        vecs[4]  = '{ALUOP_CMP,  8'h42, 8'h42, 4'h0, 8'h42, 4'h2, "cmp_42_42"};
        vecs[5]  = '{ALUOP_ROL,  8'h81, 8'h00, 4'h0, 8'h02, 4'h1, "rol_81_c0"};
        vecs[6]  = '{ALUOP_ROR,  8'h01, 8'h00, 4'h1, 8'h80, 4'h5, "ror_01_c1"};
        vecs[7]  = '{ALUOP_SHR,  8'h01, 8'h00, 4'h0, 8'h00, 4'h3, "shr_01"};
        vecs[8]  = '{ALUOP_INC,  8'h7F, 8'h00, 4'h1, 8'h80, 4'hD, "inc_7f_c1"};
        vecs[9]  = '{ALUOP_PASS, 8'h55, 8'h00, 4'h9, 8'h00, 4'hB, "pass_00_cv"};
        vecs[10] = '{ALUOP_AND,  8'hF0, 8'h0F, 4'hF, 8'h00, 4'h2, "and_f0_0f"};
        vecs[11] = '{ALUOP_OR,   8'h0F, 8'h30, 4'hF, 8'h3F, 4'h0, "or_0f_30"};
        vecs[12] = '{ALUOP_XOR,  8'hFF, 8'h0F, 4'h0, 8'hF0, 4'h4, "xor_ff_0f"};
        vecs[13] = '{ALUOP_NOT,  8'h00, 8'hAA, 4'h0, 8'hFF, 4'h4, "not_00"};
        vecs[14] = '{ALUOP_SHL,  8'h80, 8'h00, 4'h0, 8'h00, 4'h3, "shl_80"};
        vecs[15] = '{ALUOP_DEC,  8'h80, 8'h00, 4'h1, 8'h7F, 4'h9, "dec_80_c1"};
        vecs[16] = '{ALUOP_SBC,  8'h00, 8'h00, 4'h1, 8'hFF, 4'h5, "sbc_00_00_c1"};
        vecs[17] = '{ALUOP_ADC,  8'h7F, 8'h00, 4'h1, 8'h80, 4'hC, "adc_7f_00_c1"};
        vecs[18] = '{ALUOP_SUB,  8'h80, 8'h01, 4'h0, 8'h7F, 4'h8, "sub_80_01"};
        vecs[19] = '{ALUOP_DEC,  8'h00, 8'h00, 4'h0, 8'hFF, 4'h4, "dec_00"};

        // Reset held two cycles with ADD 12+34 waiting on the inputs.
        reset = 1'b1;
        drive(ALUOP_ADD, 8'h12, 8'h34, 4'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check8("reset_result", alu_bus.resultOut, 8'h00);
            check8("reset_flags", {4'h0, alu_bus.flagsOut}, 8'h00);
        end
        reset = 1'b0;
        step();
        check8("post_reset_result", alu_bus.resultOut, 8'h46);
        check8("post_reset_flags", {4'h0, alu_bus.flagsOut}, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fin);
            step();
            check8({vecs[i].name, "_result"}, alu_bus.resultOut, vecs[i].exp_r);
            check8({vecs[i].name, "_flags"}, {4'h0, alu_bus.flagsOut}, {4'h0, vecs[i].exp_f});
        end

        // Carry chain: flags fed back from the registered output.
        drive(ALUOP_ADD, 8'hFF, 8'h01, 4'h0);
        step();
        check8("chain_add_flags", {4'h0, alu_bus.flagsOut}, 8'h03);
        drive(ALUOP_ADC, 8'h00, 8'h00, alu_bus.flagsOut);
        step();
        check8("chain_adc1_result", alu_bus.resultOut, 8'h01);
        check8("chain_adc1_flags", {4'h0, alu_bus.flagsOut}, 8'h00);
        drive(ALUOP_ADC, 8'h00, 8'h00, alu_bus.flagsOut);
        step();
        check8("chain_adc2_result", alu_bus.resultOut, 8'h00);
        check8("chain_adc2_flags", {4'h0, alu_bus.flagsOut}, 8'h02);

        // Outputs must hold while inputs change mid-cycle.
        drive(ALUOP_NOT, 8'h0F, 8'h00, 4'h0);
        step();
        check8("hold_before", alu_bus.resultOut, 8'hF0);
        drive(ALUOP_PASS, 8'h00, 8'h5A, 4'hF);
        #2;
        check8("hold_result", alu_bus.resultOut, 8'hF0);
        check8("hold_flags", {4'h0, alu_bus.flagsOut}, 8'h04);
        step();
        check8("hold_next_result", alu_bus.resultOut, 8'h5A);
        check8("hold_next_flags", {4'h0, alu_bus.flagsOut}, 8'h09);

        // Reset mid-stream clears nonzero state, release computes immediately.
        reset = 1'b1;
        drive(ALUOP_SUB, 8'h05, 8'h06, 4'h0);
        step();
        check8("midreset_result", alu_bus.resultOut, 8'h00);
        check8("midreset_flags", {4'h0, alu_bus.flagsOut}, 8'h00);
        reset = 1'b0;
        step();
        check8("midrelease_result", alu_bus.resultOut, 8'hFF);
        check8("midrelease_flags", {4'h0, alu_bus.flagsOut}, 8'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_alu.md
# cpu_alu

Registered 8-bit arithmetic/logic unit for the Beaker8 CPU core. It takes a 4-bit operation code, two 8-bit operands and the current 4-bit flag register. Each clock it produces an 8-bit result and the updated flags. The CPU datapath instantiates it once and writes `flagsOut` back into its flag register.

## Interface
- No parameters; widths are fixed (8-bit data, 4-bit flags, 4-bit opcode).
- `clk` input 1 — clock; everything is on the rising edge.
- `reset` input 1 — reset, synchronous, active-high; clock clk.
- `operation` input 4 — ALU opcode (`aluop_t` from the shared package).
- `flagsIn` input 4 — current CPU flags: [0]=C carry/borrow, [1]=Z zero, [2]=N negative, [3]=V signed overflow.
- `leftOperand` input 8 — operand A.
- `rightOperand` input 8 — operand B.
- `resultOut` output 8 — registered result.
- `flagsOut` output 4 — registered flags, same bit order as `flagsIn`.

## Operation
R = result, A = left, B = right, Cin = flagsIn[0]. Unless a row states otherwise: Z = (R==0), N = R[7].
- 0 ADD: R = A+B. C = carry out of bit 7. V = signed overflow.
- 1 ADC: R = A+B+Cin. C and V as for ADD.
- 2 SUB: R = A−B. C = borrow (A<B unsigned). V = signed overflow of the subtraction.
- 3 SBC: R = A−B−Cin. C = borrow. V = signed overflow.
- 4 AND, 5 OR, 6 XOR: bitwise A op B. C=0, V=0.
- 7 NOT: R = ~A. C=0, V=0.
- 8 SHL: R = {A[6:0],0}. C = A[7]. V=0.
- 9 SHR: R = {0,A[7:1]}. C = A[0]. V=0.
- A ROL: R = {A[6:0],Cin}. C = A[7]. V=0.
- B ROR: R = {Cin,A[7:1]}. C = A[0]. V=0.
- C INC: R = A+1. C preserved from Cin. V = (A==8'h7F).
- D DEC: R = A−1. C preserved. V = (A==8'h80).
- E CMP: flags exactly as SUB. R = A (result not modified).
- F PASS: R = B. C and V preserved from flagsIn.
- Arithmetic is computed 9 bits wide. R is the low 8 bits. All wrap modulo 256 (e.g. FF+01 = 00 with C=1).
- No illegal opcodes: all 16 codes are defined.

## Timing
- On reset: `resultOut`=8'h00 and `flagsOut`=4'h0 on the next rising edge. Reset overrides any operation in flight.
- Latency is exactly 1 cycle. Inputs sampled at edge n appear on the outputs after edge n and hold until edge n+1.
- A new operation is accepted every cycle. There is no handshake, enable or busy signal.
- Outputs never depend combinationally on inputs.
- Back-to-back ADC with `flagsIn` fed from `flagsOut` must chain carry correctly.
- Reset deasserted mid-stream: the first post-reset edge computes from whatever inputs are present.

## Structure
- Shared package `cpu_pkg` holds:
  - `aluop_t` (4-bit enum: ALUOP_ADD, ALUOP_ADC, ALUOP_SUB, ALUOP_SBC, ALUOP_AND, ALUOP_OR, ALUOP_XOR, ALUOP_NOT, ALUOP_SHL, ALUOP_SHR, ALUOP_ROL, ALUOP_ROR, ALUOP_INC, ALUOP_DEC, ALUOP_CMP, ALUOP_PASS).
  - Flag index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
- One natural combinational sub-module, `cpu_alu_core`, computes next result and flags. The top level `cpu_alu` adds only the output registers and reset.

## Test plan
- Reset: assert `reset` for 2 cycles with ADD 12+34 on the inputs → `resultOut`=00, `flagsOut`=0. First edge after release → 46, flags 0.
- ADD overflow/carry cases:
  - 7F+01 → 80 with N=1, V=1, C=0.
  - FF+01 → 00 with Z=1, C=1, V=0.
- ADC chain: cycle 1 ADD FF+01 (C=1); cycle 2 ADC 00+00 using the returned flags → 01, C=0.
- SUB/CMP:
  - SUB 05−06 → FF with C=1, N=1.
  - CMP 80−01 → R=80, V=1, C=0, Z=0.
  - CMP 42−42 → R=42, Z=1.
- Shifts and rotates:
  - ROL 81 with Cin=0 → 02, C=1.
  - ROR 01 with Cin=1 → 80, C=1, N=1.
  - SHR 01 → 00, Z=1, C=1.
- Flag preservation:
  - INC 7F with Cin=1 → 80, C=1, V=1.
  - PASS B=00 with flagsIn C=1, V=1 → 00, Z=1, C=1, V=1.
  - AND F0&0F → 00, Z=1, C=0, V=0.
